// File: rtl/lsh_pkg.sv
// rtl/lsh_pkg.sv - shared base encoding, window FSM states and default sizes
package lsh_pkg;

  typedef logic [1:0] base_t;

  localparam base_t BASE_A = 2'd0;
  localparam base_t BASE_C = 2'd1;
  localparam base_t BASE_G = 2'd2;
  localparam base_t BASE_T = 2'd3;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } window_state_t;

  localparam int DEF_WINDOW_SIZE      = 128;
  localparam int DEF_WINDOW_STRIDE    = 64;
  localparam int DEF_LOG2_WINDOW_SIZE = 7;
  localparam int DEF_LOG2_MAX_WINDOWS = 10;

endpackage

// File: rtl/base_shift_reg.sv
// rtl/base_shift_reg.sv - DEPTH x 2-bit base shift register, oldest base at tap 0
module base_shift_reg
  import lsh_pkg::*;
#(
  parameter int DEPTH = DEF_WINDOW_SIZE
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  shift_en_i,
  input  base_t base_i,
  output base_t taps_o [0:DEPTH-1]
);

  base_t sr_q [0:DEPTH-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= BASE_A;
    end else if (shift_en_i) begin
      for (int i = 0; i < DEPTH - 1; i++) sr_q[i] <= sr_q[i+1];
      sr_q[DEPTH-1] <= base_i;
    end
  end

  assign taps_o = sr_q;

endmodule

// File: rtl/window_streamer.sv
// rtl/window_streamer.sv - builds strided sliding windows from a base stream
module window_streamer
  import lsh_pkg::*;
#(
  parameter int WINDOW_SIZE      = DEF_WINDOW_SIZE,
  parameter int WINDOW_STRIDE    = DEF_WINDOW_STRIDE,
  parameter int LOG2_WINDOW_SIZE = DEF_LOG2_WINDOW_SIZE,
  parameter int LOG2_MAX_WINDOWS = DEF_LOG2_MAX_WINDOWS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  base_t                       base_in,
  input  logic                        base_valid,
  input  logic                        base_last,
  output logic                        base_ready,
  output base_t                       window [0:WINDOW_SIZE-1],
  output logic                        window_valid,
  input  logic                        window_ready,
  output logic                        window_last,
  output logic [LOG2_MAX_WINDOWS-1:0] window_index,
  output logic                        short_seq
);

  localparam int CW = LOG2_WINDOW_SIZE + 1;
  localparam logic [CW-1:0] NEED_FULL   = CW'(WINDOW_SIZE);
  localparam logic [CW-1:0] NEED_STRIDE = CW'(WINDOW_STRIDE);

  window_state_t               state_q, state_d;
  logic [CW-1:0]               need_q, need_d;
  logic [LOG2_MAX_WINDOWS-1:0] idx_q, idx_d;
  logic                        last_q, last_d;
  logic                        short_q, short_d;
  logic                        base_acc, win_acc;

  assign base_ready   = (state_q == FILL);
  assign window_valid = (state_q == EMIT);
  assign base_acc     = base_valid & base_ready;
  assign win_acc      = window_valid & window_ready;
  assign window_last  = last_q;
  assign window_index = idx_q;
  assign short_seq    = short_q;

  base_shift_reg #(.DEPTH(WINDOW_SIZE)) u_shift (
    .clk_i      (clk),
    .rst_ni     (reset),
    .shift_en_i (base_acc),
    .base_i     (base_in),
    .taps_o     (window)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      need_q  <= NEED_FULL;
      idx_q   <= '0;
      last_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      need_q  <= need_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      short_q <= short_d;
    end
  end

  always_comb begin
    state_d = state_q;
    need_d  = need_q;
    idx_d   = idx_q;
    last_d  = last_q;
    short_d = 1'b0;
    case (state_q)
      FILL: begin
        if (base_acc) begin
          if (need_q == CW'(1)) begin
            state_d = EMIT;
            last_d  = base_last;
            need_d  = need_q - CW'(1);
          end else if (base_last) begin
            // Stale window contents are left in place; a full refill overwrites them.
            short_d = (idx_q == '0);
            need_d  = NEED_FULL;
            idx_d   = '0;
          end else begin
            need_d = need_q - CW'(1);
          end
        end
      end
      EMIT: begin
        if (win_acc) begin
          state_d = FILL;
          if (last_q) begin
            need_d = NEED_FULL;
            idx_d  = '0;
            last_d = 1'b0;
          end else begin
            need_d = NEED_STRIDE;
            idx_d  = idx_q + LOG2_MAX_WINDOWS'(1);
          end
        end
      end
    endcase
  end

endmodule
